// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared FSM type, sizing helpers and default constants for the CIM macro
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } cim_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Plane sum width: one sign bit plus headroom for N_IN signed weights.
  function automatic int psum_width(input int data_width, input int n_in);
    return data_width + clog2(n_in) + 1;
  endfunction

  function automatic int adc_max(input int precision);
    return (1 << (precision - 1)) - 1;
  endfunction

  function automatic int adc_min(input int precision);
    return -(1 << (precision - 1));
  endfunction

  // Values for the default macro configuration.
  localparam int COL_DEPTH  = (1 << 10) / 8;
  localparam int PSUM_WIDTH = psum_width(8, 8);
  localparam int ADC_MAX    = adc_max(6);
  localparam int ADC_MIN    = adc_min(6);

endpackage

// File: rtl/cim_adc_sat.sv
// rtl/cim_adc_sat.sv - ADC model: arithmetic right shift of a plane sum, then signed saturation
//   i_psum : signed column plane sum (PSUM_WIDTH)
//   o_adc  : signed quantised code (ADC_PRECISION)
module cim_adc_sat
  import cim_pkg::*;
#(
  parameter int PSUM_WIDTH    = 12,
  parameter int ADC_PRECISION = 6,
  parameter int ADC_SHIFT     = 5
) (
  input  logic signed [PSUM_WIDTH-1:0]    i_psum,
  output logic signed [ADC_PRECISION-1:0] o_adc
);

  localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX = PSUM_WIDTH'(adc_max(ADC_PRECISION));
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN = PSUM_WIDTH'(adc_min(ADC_PRECISION));

  logic signed [PSUM_WIDTH-1:0] w_shifted;

  assign w_shifted = i_psum >>> ADC_SHIFT;

  always_comb begin
    o_adc = w_shifted[ADC_PRECISION-1:0];
    if (w_shifted > SAT_MAX) begin
      o_adc = SAT_MAX[ADC_PRECISION-1:0];
    end else if (w_shifted < SAT_MIN) begin
      o_adc = SAT_MIN[ADC_PRECISION-1:0];
    end
  end

endmodule

// File: rtl/cim_bitserial_macro.sv
// rtl/cim_bitserial_macro.sv - bit-serial compute-in-memory GeMM macro with weight memory and output registers
//   clk, rst         : clock, synchronous active-high reset
//   cs, write        : bus select, byte-wise weight write (IDLE only)
//   address          : write/read address, row base for an op
//   input_data       : four weight bytes, [31:24] goes to address+0
//   cim_input        : activations, row r at [r*P +: P]
//   start            : launch one op; partial_sum picks accumulate vs overwrite
//   reset_output     : clear all output registers
//   cim, output_reg  : read mux select (output register / weight memory)
//   busy, done       : op in progress, one-cycle completion pulse
//   cim_output       : sign-extended register or weight read-back
module cim_bitserial_macro
  import cim_pkg::*;
#(
  parameter int DATA_WIDTH             = 8,
  parameter int ADDR_WIDTH             = 10,
  parameter int CIM_INPUT_PRECISION    = 4,
  parameter int CIM_INPUT_PARALLELISM  = 8,
  parameter int CIM_OUTPUT_PARALLELISM = 8,
  parameter int ADC_PRECISION          = 6,
  parameter int ADC_SHIFT              = 5,
  parameter int ACC_WIDTH              = 32
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 cs,
  input  logic                                                 write,
  input  logic [31:0]                                          address,
  input  logic [31:0]                                          input_data,
  input  logic [CIM_INPUT_PARALLELISM*CIM_INPUT_PRECISION-1:0] cim_input,
  input  logic                                                 start,
  input  logic                                                 partial_sum,
  input  logic                                                 reset_output,
  input  logic                                                 cim,
  input  logic [clog2(CIM_OUTPUT_PARALLELISM)-1:0]             output_reg,
  output logic                                                 busy,
  output logic                                                 done,
  output logic [31:0]                                          cim_output
);

  localparam int N_IN      = CIM_INPUT_PARALLELISM;
  localparam int N_OUT     = CIM_OUTPUT_PARALLELISM;
  localparam int P         = CIM_INPUT_PRECISION;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int COL_BITS  = clog2(N_OUT);
  localparam int ROW_BITS  = ADDR_WIDTH - COL_BITS;
  localparam int PSUM_W    = psum_width(DATA_WIDTH, N_IN);
  localparam int BIT_W     = clog2(P);

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  cim_state_e r_state, w_state_nxt;

  logic [N_IN*P-1:0]                r_act;
  logic [ROW_BITS-1:0]              r_row_base;
  logic                             r_psum_mode;
  logic [BIT_W-1:0]                 r_bit;
  logic                             r_drain;
  logic signed [ADC_PRECISION-1:0]  r_adc [N_OUT];
  logic [ACC_WIDTH-1:0]             r_op  [N_OUT];
  logic [ACC_WIDTH-1:0]             r_out [N_OUT];

  logic                             w_wr_en;
  logic                             w_start;
  logic [P-1:0]                     w_row;
  logic [N_IN-1:0]                  w_plane;
  logic signed [PSUM_W-1:0]         w_psum [N_OUT];
  logic signed [ADC_PRECISION-1:0]  w_adc  [N_OUT];
  logic                             w_unused_addr_hi;

  assign w_unused_addr_hi = ^address[31:ADDR_WIDTH];

  // A simultaneous write blocks start.
  assign w_wr_en = cs && write && (r_state == IDLE);
  assign w_start = cs && start && !write && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        r_mem[address[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k)] <= DATA_WIDTH'(input_data[31-8*k -: 8]);
      end
    end
  end

  // Column c owns a contiguous COL_DEPTH slice; the row offset wraps inside it.
  always_comb begin
    w_row   = '0;
    w_plane = '0;
    for (int r = 0; r < N_IN; r++) begin
      w_row      = r_act[r*P +: P];
      w_plane[r] = w_row[r_bit];
    end
    for (int c = 0; c < N_OUT; c++) begin
      w_psum[c] = '0;
      for (int r = 0; r < N_IN; r++) begin
        if (w_plane[r]) begin
          w_psum[c] = w_psum[c]
                    + PSUM_W'(signed'(r_mem[{COL_BITS'(c), r_row_base + ROW_BITS'(r)}]));
        end
      end
    end
  end

  for (genvar c = 0; c < N_OUT; c++) begin : g_adc
    cim_adc_sat #(
      .PSUM_WIDTH   (PSUM_W),
      .ADC_PRECISION(ADC_PRECISION),
      .ADC_SHIFT    (ADC_SHIFT)
    ) u_adc (
      .i_psum(w_psum[c]),
      .o_adc (w_adc[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // COMPUTE runs P plane cycles plus one drain cycle, because the ADC code
  // is registered before it enters the shift-accumulator.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (r_drain) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act       <= '0;
      r_row_base  <= '0;
      r_psum_mode <= 1'b0;
      r_bit       <= '0;
      r_drain     <= 1'b0;
      for (int c = 0; c < N_OUT; c++) begin
        r_adc[c] <= '0;
        r_op[c]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_act       <= cim_input;
            r_row_base  <= address[ROW_BITS-1:0];
            r_psum_mode <= partial_sum;
            r_bit       <= BIT_W'(P - 1);
            r_drain     <= 1'b0;
            for (int c = 0; c < N_OUT; c++) begin
              r_adc[c] <= '0;
              r_op[c]  <= '0;
            end
          end
        end
        COMPUTE: begin
          for (int c = 0; c < N_OUT; c++) begin
            r_adc[c] <= w_adc[c];
            r_op[c]  <= (r_op[c] << 1) + ACC_WIDTH'(r_adc[c]);
          end
          if (r_bit != '0) begin
            r_bit <= r_bit - BIT_W'(1);
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // reset_output beats the DONE commit.
  always_ff @(posedge clk) begin
    if (rst || reset_output) begin
      for (int c = 0; c < N_OUT; c++) r_out[c] <= '0;
    end else if (r_state == DONE) begin
      for (int c = 0; c < N_OUT; c++) begin
        r_out[c] <= r_psum_mode ? (r_out[c] + r_op[c]) : r_op[c];
      end
    end
  end

  always_comb begin
    cim_output = '0;
    if (cim) begin
      if (int'(output_reg) < N_OUT) begin
        cim_output = 32'(signed'(r_out[output_reg]));
      end
    end else begin
      cim_output = 32'(signed'(r_mem[address[ADDR_WIDTH-1:0]]));
    end
  end

endmodule

// File: tb/tb_cim_bitserial_macro.sv
// tb/tb_cim_bitserial_macro.sv - directed table-driven bench for cim_bitserial_macro (default and ADC_SHIFT=0)
module tb_cim_bitserial_macro;

  localparam int P   = 4;
  localparam int LAT = P + 1;

  logic        clk = 1'b0;
  logic        rst, cs, write, start, partial_sum, reset_output, cim;
  logic [31:0] address, input_data, cim_input;
  logic [2:0]  output_reg;
  logic        busy0, done0, busy1, done1;
  logic [31:0] out0, out1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cim_bitserial_macro u_dut (
    .clk(clk), .rst(rst), .cs(cs), .write(write), .address(address),
    .input_data(input_data), .cim_input(cim_input), .start(start),
    .partial_sum(partial_sum), .reset_output(reset_output), .cim(cim),
    .output_reg(output_reg), .busy(busy0), .done(done0), .cim_output(out0)
  );

  cim_bitserial_macro #(.ADC_SHIFT(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .cs(cs), .write(write), .address(address),
    .input_data(input_data), .cim_input(cim_input), .start(start),
    .partial_sum(partial_sum), .reset_output(reset_output), .cim(cim),
    .output_reg(output_reg), .busy(busy1), .done(done1), .cim_output(out1)
  );

  typedef struct {
    int          col;
    int          base;
    logic [7:0]  wt;
    logic [31:0] act;
    logic        psum;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; address = a; input_data = d;
    tick();
    write = 1'b0;
  endtask

  task automatic rd_reg(input int idx, output logic [31:0] o0, output logic [31:0] o1);
    cim = 1'b1; output_reg = 3'(idx);
    #1;
    o0 = out0; o1 = out1;
  endtask

  task automatic rd_mem(input logic [31:0] a, output logic [31:0] o0);
    cim = 1'b0; address = a;
    #1;
    o0 = out0;
  endtask

  // Launches an op, returns the cycle index of the done pulse (-1 if none), then
  // steps past the commit edge.
  task automatic run_op(input logic [31:0] act, input logic psum, input logic [31:0] base,
                        output int lat);
    cs = 1'b1; address = base; cim_input = act; partial_sum = psum; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick();
      if (done0) lat = k;
    end
    tick();
  endtask

  initial begin
    logic [31:0] o0, o1;
    int          lat;
    int          seen_done;

    vecs[0] = '{0, 0,  8'h04, 32'hFFFF_FFFF, 1'b0, 32'd15,          32'd465};
    vecs[1] = '{0, 0,  8'h04, 32'hFFFF_FFFF, 1'b1, 32'd30,          32'd930};
    vecs[2] = '{3, 0,  8'h80, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FE20,   32'hFFFF_FE20};
    vecs[3] = '{5, 0,  8'h7F, 32'hFFFF_FFFF, 1'b0, 32'd465,         32'd465};
    vecs[4] = '{1, 0,  8'h04, 32'hCCCC_CCCC, 1'b0, 32'd12,          32'd372};
    vecs[5] = '{2, 0,  8'h04, 32'h0000_FFFF, 1'b0, 32'd0,           32'd240};
    vecs[6] = '{4, 40, 8'h03, 32'hFFFF_FFFF, 1'b0, 32'd0,           32'd360};
    vecs[7] = '{6, 0,  8'hFC, 32'h0000_FFFF, 1'b0, 32'hFFFF_FFF1,   32'hFFFF_FF10};

    rst = 1'b1; cs = 1'b0; write = 1'b0; start = 1'b0; partial_sum = 1'b0;
    reset_output = 1'b0; cim = 1'b1; address = '0; input_data = '0;
    cim_input = '0; output_reg = '0;
    tick(); tick();
    rst = 1'b0;

    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_done", 32'(done0), 32'd0);
    rd_reg(0, o0, o1);
    check("reset_out0", o0, 32'd0);

    for (int a = 0; a < 1024; a += 4) wr(a, 32'h0);

    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].col * 128 + vecs[i].base,     {4{vecs[i].wt}});
      wr(vecs[i].col * 128 + vecs[i].base + 4, {4{vecs[i].wt}});
      run_op(vecs[i].act, vecs[i].psum, vecs[i].base, lat);
      check($sformatf("vec%0d_done_latency", i), lat, LAT);
      rd_reg(vecs[i].col, o0, o1);
      check($sformatf("vec%0d_out_shift5", i), o0, vecs[i].exp0);
      check($sformatf("vec%0d_out_shift0", i), o1, vecs[i].exp1);
      if (i == 0) begin
        rd_reg(7, o0, o1);
        check("vec0_other_column_zero", o0, 32'd0);
      end
    end

    reset_output = 1'b1;
    tick();
    reset_output = 1'b0;
    rd_reg(6, o0, o1);
    check("reset_output_shift5", o0, 32'd0);
    check("reset_output_shift0", o1, 32'd0);

    wr(126, 32'h0102_0304);
    for (int k = 0; k < 4; k++) begin
      rd_mem(126 + k, o0);
      check($sformatf("wr_wrap_mem%0d", 126 + k), o0, 32'(k + 1));
    end
    wr(200, 32'h80FF_7F00);
    rd_mem(200, o0);
    check("mem_read_sign_ext", o0, 32'hFFFF_FF80);

    wr(124, 32'h0000_0404);
    run_op(32'hFFFF_FFFF, 1'b0, 126, lat);
    check("row_wrap_latency", lat, LAT);
    rd_reg(0, o0, o1);
    check("row_wrap_out0", o0, 32'd15);

    cs = 1'b1; write = 1'b1; start = 1'b1; address = 300; input_data = 32'h1122_3344;
    tick();
    write = 1'b0; start = 1'b0;
    check("write_beats_start_busy", 32'(busy0), 32'd0);
    rd_mem(300, o0);
    check("write_beats_start_mem", o0, 32'h11);

    cs = 1'b1; address = 0; cim_input = 32'hFFFF_FFFF; partial_sum = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    write = 1'b1; start = 1'b1; input_data = 32'h0; address = 0;
    tick();
    write = 1'b0; start = 1'b0;
    lat = -1;
    for (int k = 3; k <= 20 && lat < 0; k++) begin
      tick();
      if (done0) lat = k;
    end
    tick();
    check("busy_ignore_latency", lat, LAT);
    rd_reg(0, o0, o1);
    check("busy_ignore_out0", o0, 32'd15);
    rd_mem(0, o0);
    check("busy_ignore_mem0", o0, 32'h4);
    tick(); tick();
    check("busy_ignore_no_restart", 32'(busy0), 32'd0);

    cs = 1'b1; address = 0; cim_input = 32'hFFFF_FFFF; partial_sum = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_abort_busy", 32'(busy0), 32'd0);
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (done0 || done1) seen_done = 1;
      tick();
    end
    check("rst_abort_no_done", seen_done, 0);
    rd_reg(0, o0, o1);
    check("rst_abort_out0_shift5", o0, 32'd0);
    check("rst_abort_out0_shift0", o1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
